// File: rtl/idex_stage.sv
// ----------------------------------------------------------------------------
// idex_stage
//
// ID/EX pipeline register for the 64-bit LEGv8 pipeline. It captures the
// register-file read data, the immediate, the register indices and the
// decoded control word from the decode stage and presents them to EX one
// clock later.
//
// The stage also owns load-use hazard detection. When EX holds a load whose
// destination matches one of the decode-stage source registers, stall_d is
// raised so that PC and IF/ID hold, and a bubble is written into EX. A taken
// branch (flush) also turns the incoming instruction into a bubble and takes
// priority over the stall. A saturating counter records the number of stall
// cycles since reset.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   valid_d      decode stage holds a real instruction
//   rd1_d/rd2_d  register-file read data (N bits)
//   imm_d        sign-extended immediate (N bits)
//   ra1_d/ra2_d  source register indices
//   wa3_d        destination register index
//   ctl_d        {regWrite, memRead, memWrite, memtoReg, aluSrc, branch,
//                 aluControl[2:0]}
//   flush        taken branch; discard the decode instruction
//   *_e          registered copies of the decode fields for EX
//   valid_e      EX holds a real instruction
//   stall_d      combinational; hold PC and IF/ID this cycle
//   stall_count  saturating count of stall cycles since reset (CW bits)
// ----------------------------------------------------------------------------
module idex_stage #(
    parameter int N  = 64,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_d,
    input  logic [N-1:0]  rd1_d,
    input  logic [N-1:0]  rd2_d,
    input  logic [N-1:0]  imm_d,
    input  logic [4:0]    ra1_d,
    input  logic [4:0]    ra2_d,
    input  logic [4:0]    wa3_d,
    input  logic [8:0]    ctl_d,
    input  logic          flush,
    output logic [N-1:0]  rd1_e,
    output logic [N-1:0]  rd2_e,
    output logic [N-1:0]  imm_e,
    output logic [4:0]    ra1_e,
    output logic [4:0]    ra2_e,
    output logic [4:0]    wa3_e,
    output logic [8:0]    ctl_e,
    output logic          valid_e,
    output logic          stall_d,
    output logic [CW-1:0] stall_count
);

    // Bit position of memRead inside the packed control word.
    localparam int         MEM_READ_BIT = 7;
    // XZR reads as zero and is never really written, so it cannot cause a hazard.
    localparam logic [4:0] XZR          = 5'd31;

    logic [N-1:0]  rd1_e_q, rd1_e_d;
    logic [N-1:0]  rd2_e_q, rd2_e_d;
    logic [N-1:0]  imm_e_q, imm_e_d;
    logic [4:0]    ra1_e_q, ra1_e_d;
    logic [4:0]    ra2_e_q, ra2_e_d;
    logic [4:0]    wa3_e_q, wa3_e_d;
    logic [8:0]    ctl_e_q, ctl_e_d;
    logic          valid_e_q, valid_e_d;
    logic [CW-1:0] stall_count_q, stall_count_d;

    logic          haz;
    logic          src_match;

    // Load-use hazard: a valid load in EX writes a register that the valid
    // decode instruction reads. Only EX registers and decode inputs feed this,
    // so the bubble it inserts clears memRead and the hazard drops next cycle.
    always_comb begin
        src_match = (ra1_d == wa3_e_q) || (ra2_d == wa3_e_q);
        haz       = valid_d && valid_e_q && ctl_e_q[MEM_READ_BIT] &&
                    (wa3_e_q != XZR) && src_match;
    end

    // A flush discards the decode instruction anyway, so there is nothing to hold.
    assign stall_d = haz && !flush;

    // Next-state selection: flush or hazard writes a fully zeroed bubble,
    // otherwise the decode fields load. An invalid decode slot never carries
    // live controls into EX. The stall counter only counts real stalls and
    // sticks at all-ones instead of wrapping.
    always_comb begin
        rd1_e_d       = '0;
        rd2_e_d       = '0;
        imm_e_d       = '0;
        ra1_e_d       = '0;
        ra2_e_d       = '0;
        wa3_e_d       = '0;
        ctl_e_d       = '0;
        valid_e_d     = 1'b0;
        stall_count_d = stall_count_q;

        if (!flush && !haz) begin
            rd1_e_d   = rd1_d;
            rd2_e_d   = rd2_d;
            imm_e_d   = imm_d;
            ra1_e_d   = ra1_d;
            ra2_e_d   = ra2_d;
            wa3_e_d   = wa3_d;
            ctl_e_d   = valid_d ? ctl_d : 9'd0;
            valid_e_d = valid_d;
        end

        if (stall_d && (stall_count_q != {CW{1'b1}})) begin
            stall_count_d = stall_count_q + CW'(1);
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_e_q       <= '0;
            rd2_e_q       <= '0;
            imm_e_q       <= '0;
            ra1_e_q       <= '0;
            ra2_e_q       <= '0;
            wa3_e_q       <= '0;
            ctl_e_q       <= '0;
            valid_e_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            rd1_e_q       <= rd1_e_d;
            rd2_e_q       <= rd2_e_d;
            imm_e_q       <= imm_e_d;
            ra1_e_q       <= ra1_e_d;
            ra2_e_q       <= ra2_e_d;
            wa3_e_q       <= wa3_e_d;
            ctl_e_q       <= ctl_e_d;
            valid_e_q     <= valid_e_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rd1_e       = rd1_e_q;
    assign rd2_e       = rd2_e_q;
    assign imm_e       = imm_e_q;
    assign ra1_e       = ra1_e_q;
    assign ra2_e       = ra2_e_q;
    assign wa3_e       = wa3_e_q;
    assign ctl_e       = ctl_e_q;
    assign valid_e     = valid_e_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_idex_stage.sv
// ----------------------------------------------------------------------------
// tb_idex_stage
//
// Directed bench for idex_stage with a 4-bit stall counter so saturation is
// reachable. A small reference model of the EX register computes the expected
// state whenever decode inputs are driven; that expectation is queued and
// compared once the clock edge has moved the instruction into EX.
// ----------------------------------------------------------------------------
module tb_idex_stage;

    localparam int N  = 64;
    localparam int CW = 4;

    localparam logic [8:0] CTL_ADD  = 9'b1_0_0_0_0_0_010;
    localparam logic [8:0] CTL_LDUR = 9'b1_1_0_1_1_0_010;

    logic          clk;
    logic          reset;
    logic          valid_d;
    logic [N-1:0]  rd1_d, rd2_d, imm_d;
    logic [4:0]    ra1_d, ra2_d, wa3_d;
    logic [8:0]    ctl_d;
    logic          flush;
    logic [N-1:0]  rd1_e, rd2_e, imm_e;
    logic [4:0]    ra1_e, ra2_e, wa3_e;
    logic [8:0]    ctl_e;
    logic          valid_e;
    logic          stall_d;
    logic [CW-1:0] stall_count;

    typedef struct {
        logic [N-1:0]  rd1;
        logic [N-1:0]  rd2;
        logic [N-1:0]  imm;
        logic [4:0]    ra1;
        logic [4:0]    ra2;
        logic [4:0]    wa3;
        logic [8:0]    ctl;
        logic          valid;
        logic [CW-1:0] cnt;
    } ex_t;

    ex_t sb[$];
    ex_t model;

    int total = 0;
    int bad   = 0;

    idex_stage #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_d     (valid_d),
        .rd1_d       (rd1_d),
        .rd2_d       (rd2_d),
        .imm_d       (imm_d),
        .ra1_d       (ra1_d),
        .ra2_d       (ra2_d),
        .wa3_d       (wa3_d),
        .ctl_d       (ctl_d),
        .flush       (flush),
        .rd1_e       (rd1_e),
        .rd2_e       (rd2_e),
        .imm_e       (imm_e),
        .ra1_e       (ra1_e),
        .ra2_e       (ra2_e),
        .wa3_e       (wa3_e),
        .ctl_e       (ctl_e),
        .valid_e     (valid_e),
        .stall_d     (stall_d),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        model.rd1   = '0;
        model.rd2   = '0;
        model.imm   = '0;
        model.ra1   = '0;
        model.ra2   = '0;
        model.wa3   = '0;
        model.ctl   = '0;
        model.valid = 1'b0;
        model.cnt   = '0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd1_e"}, rd1_e, '0);
        check({tag, ".rd2_e"}, rd2_e, '0);
        check({tag, ".imm_e"}, imm_e, '0);
        check({tag, ".ra1_e"}, N'(ra1_e), '0);
        check({tag, ".ra2_e"}, N'(ra2_e), '0);
        check({tag, ".wa3_e"}, N'(wa3_e), '0);
        check({tag, ".ctl_e"}, N'(ctl_e), '0);
        check({tag, ".valid_e"}, N'(valid_e), '0);
        check({tag, ".stall_count"}, N'(stall_count), '0);
        check({tag, ".stall_d"}, N'(stall_d), '0);
    endtask

    task automatic drive(input logic v, input logic [N-1:0] r1, input logic [N-1:0] r2,
                         input logic [N-1:0] im, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] w3, input logic [8:0] c, input logic f);
        valid_d = v;
        rd1_d   = r1;
        rd2_d   = r2;
        imm_d   = im;
        ra1_d   = a1;
        ra2_d   = a2;
        wa3_d   = w3;
        ctl_d   = c;
        flush   = f;
    endtask

    // Checks stall_d against the model, queues the expected EX contents for
    // the coming edge, then pops and compares them after the edge.
    task automatic step(input string tag);
        logic h;
        ex_t  nxt;
        ex_t  got;
        #1;
        h = valid_d && model.valid && model.ctl[7] && (model.wa3 != 5'd31) &&
            ((ra1_d == model.wa3) || (ra2_d == model.wa3));
        check({tag, ".stall_d"}, N'(stall_d), N'(h && !flush));

        nxt = '{rd1: '0, rd2: '0, imm: '0, ra1: '0, ra2: '0, wa3: '0,
                ctl: '0, valid: 1'b0, cnt: model.cnt};
        if (!flush && h && (model.cnt != {CW{1'b1}})) nxt.cnt = model.cnt + 1'b1;
        if (!flush && !h) begin
            nxt.rd1   = rd1_d;
            nxt.rd2   = rd2_d;
            nxt.imm   = imm_d;
            nxt.ra1   = ra1_d;
            nxt.ra2   = ra2_d;
            nxt.wa3   = wa3_d;
            nxt.ctl   = valid_d ? ctl_d : 9'd0;
            nxt.valid = valid_d;
        end
        sb.push_back(nxt);
        model = nxt;

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            check({tag, ".rd1_e"}, rd1_e, got.rd1);
            check({tag, ".rd2_e"}, rd2_e, got.rd2);
            check({tag, ".imm_e"}, imm_e, got.imm);
            check({tag, ".ra1_e"}, N'(ra1_e), N'(got.ra1));
            check({tag, ".ra2_e"}, N'(ra2_e), N'(got.ra2));
            check({tag, ".wa3_e"}, N'(wa3_e), N'(got.wa3));
            check({tag, ".ctl_e"}, N'(ctl_e), N'(got.ctl));
            check({tag, ".valid_e"}, N'(valid_e), N'(got.valid));
            check({tag, ".stall_count"}, N'(stall_count), N'(got.cnt));
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 9'd0, 1'b0);
        model_clear();

        // Reset held with random decode inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            check_all_zero("reset_hold");
        end
        reset = 1'b1;

        // ADD X1, X2, X3.
        drive(1'b1, 64'd2, 64'd3, 64'd0, 5'd2, 5'd3, 5'd1, CTL_ADD, 1'b0);
        step("add_first");
        check("add_first.rd1_exact", rd1_e, 64'd2);
        check("add_first.wa3_exact", N'(wa3_e), 64'd1);

        // LDUR X5 then a dependent ADD X7, X5, X8: one bubble, then load.
        drive(1'b1, 64'h1000, 64'h0, 64'h8, 5'd6, 5'd31, 5'd5, CTL_LDUR, 1'b0);
        step("ldur_x5");
        drive(1'b1, 64'hAAAA, 64'hBBBB, 64'h0, 5'd5, 5'd8, 5'd7, CTL_ADD, 1'b0);
        step("loaduse_bubble");
        check("loaduse_bubble.count_exact", N'(stall_count), 64'd1);
        step("loaduse_release");
        check("loaduse_release.valid_exact", N'(valid_e), 64'd1);

        // Same dependency through ra2.
        drive(1'b1, 64'h0, 64'h0, 64'h10, 5'd9, 5'd31, 5'd12, CTL_LDUR, 1'b0);
        step("ldur_x12");
        drive(1'b1, 64'h1, 64'h2, 64'h0, 5'd3, 5'd12, 5'd13, CTL_ADD, 1'b0);
        step("loaduse_ra2_bubble");
        step("loaduse_ra2_release");

        // LDUR X31 never creates a hazard; neither does a non-load producer.
        drive(1'b1, 64'h0, 64'h0, 64'h18, 5'd4, 5'd31, 5'd31, CTL_LDUR, 1'b0);
        step("ldur_xzr");
        drive(1'b1, 64'h5, 64'h6, 64'h0, 5'd2, 5'd31, 5'd10, CTL_ADD, 1'b0);
        step("xzr_no_stall");
        drive(1'b1, 64'h7, 64'h8, 64'h0, 5'd1, 5'd2, 5'd5, CTL_ADD, 1'b0);
        step("add_x5");
        drive(1'b1, 64'h9, 64'hA, 64'h0, 5'd5, 5'd5, 5'd6, CTL_ADD, 1'b0);
        step("nonload_no_stall");

        // Flush together with a hazard: flush wins, count unchanged.
        drive(1'b1, 64'h0, 64'h0, 64'h20, 5'd2, 5'd31, 5'd9, CTL_LDUR, 1'b0);
        step("ldur_x9");
        drive(1'b1, 64'hC, 64'hD, 64'h0, 5'd9, 5'd1, 5'd11, CTL_ADD, 1'b1);
        step("flush_over_stall");
        drive(1'b1, 64'hE, 64'hF, 64'h1, 5'd3, 5'd4, 5'd14, CTL_ADD, 1'b0);
        step("after_flush");

        // Invalid decode with live-looking controls loads as an empty slot.
        drive(1'b0, 64'h11, 64'h22, 64'h33, 5'd1, 5'd2, 5'd3, 9'h1FF, 1'b0);
        step("invalid_decode");
        drive(1'b1, 64'h44, 64'h55, 64'h0, 5'd3, 5'd3, 5'd15, CTL_ADD, 1'b0);
        step("after_invalid_no_stall");
        drive(1'b1, 64'h0, 64'h0, 64'h28, 5'd2, 5'd31, 5'd16, CTL_LDUR, 1'b0);
        step("ldur_x16");
        drive(1'b0, 64'h0, 64'h0, 64'h0, 5'd16, 5'd16, 5'd17, CTL_ADD, 1'b0);
        step("invalid_vs_load_no_stall");

        // Saturation: 20 load-use pairs drive the 4-bit counter to 15 and hold.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'h0, 64'h0, 64'(i), 5'd2, 5'd31, 5'd4, CTL_LDUR, 1'b0);
            step("sat_ldur");
            drive(1'b1, 64'(i), 64'h1, 64'h0, 5'd4, 5'd1, 5'd8, CTL_ADD, 1'b0);
            step("sat_bubble");
            step("sat_release");
        end
        check("saturation.count_exact", N'(stall_count), 64'd15);

        // Reset asserted while a stall is pending clears everything immediately.
        drive(1'b1, 64'h0, 64'h0, 64'h30, 5'd2, 5'd31, 5'd20, CTL_LDUR, 1'b0);
        step("ldur_x20");
        drive(1'b1, 64'h3, 64'h4, 64'h0, 5'd20, 5'd1, 5'd21, CTL_ADD, 1'b0);
        #1;
        check("midstall.stall_d_before", N'(stall_d), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("midstall_async");
        model_clear();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 64'h66, 64'h77, 64'h0, 5'd20, 5'd1, 5'd22, CTL_ADD, 1'b0);
        step("after_reset_resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
